// File: rtl/fifo_rd_defs.sv
// Shared definitions for the FIFO burst reader: FSM state encoding and skid depth.
package fifo_rd_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order skid buffer that absorbs the FIFO's registered read latency.
module fifo_rd_skid
  import fifo_rd_defs::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic             head_q;
  logic [1:0]       cnt_q;
  logic             tail;

  // With two slots the tail is the head when the count is even, the other slot when odd.
  assign tail  = head_q ^ cnt_q[0];
  assign valid = (cnt_q != 2'd0);
  assign data  = mem_q[head_q];
  assign cnt   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[tail] <= push_data;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst master for sync_fifo: issues reads for a commanded burst and streams
// the words out on a valid/ready interface at up to one word per clock.
module fifo_burst_reader
  import fifo_rd_defs::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             busy,
  output logic             done,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);

  state_e           state_q;
  logic [LEN_W-1:0] req_left_q;
  logic [LEN_W-1:0] sent_left_q;
  logic             inflight_q;
  logic             busy_q;
  logic             done_q;

  logic             pop;
  logic [1:0]       skid_cnt;
  logic [2:0]       occupancy;

  assign pop = m_valid && m_ready;

  // Occupancy after this edge if no new read is issued; pop implies skid_cnt >= 1.
  assign occupancy = {1'b0, skid_cnt} + {2'b00, inflight_q} - {2'b00, pop};

  assign fifo_rd_en = (state_q == ST_RUN) && !fifo_empty && (req_left_q != '0) &&
                      (occupancy < 3'd2);

  assign busy = busy_q;
  assign done = done_q;

  fifo_rd_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data(fifo_dout),
    .pop      (pop),
    .valid    (m_valid),
    .data     (m_data),
    .cnt      (skid_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_left_q  <= '0;
      sent_left_q <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      done_q     <= 1'b0;
      if (fifo_rd_en) begin
        req_left_q <= req_left_q - LEN_W'(1);
      end
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_start) begin
            if (cmd_len != '0) begin
              state_q     <= ST_RUN;
              req_left_q  <= cmd_len;
              sent_left_q <= cmd_len;
              busy_q      <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pop) begin
            sent_left_q <= sent_left_q - LEN_W'(1);
            if (sent_left_q == LEN_W'(1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based sync_fifo and burst model, per-cycle compares.
module tb_fifo_burst_reader;

  localparam int WIDTH = 8;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_start = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             busy;
  logic             done;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             fifo_empty = 1'b1;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready = 1'b0;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .WIDTH(WIDTH),
    .LEN_W(LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_start (cmd_start),
    .cmd_len   (cmd_len),
    .busy      (busy),
    .done      (done),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [7:0] fq[$];       // contents of the modelled sync_fifo
  logic [7:0] exp_q[$];    // words owed to the consumer, in order
  logic [7:0] seen_q[$];   // words actually handshaked
  int         seen_cyc[$];

  int         remaining = 0;
  logic       busy_exp = 1'b0;
  logic       done_exp = 1'b0;
  logic       done_next;
  logic       idle;
  int         outstanding = 0;
  int         done_cnt = 0;
  int         rd_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Environment and reference model, evaluated on pre-edge values.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      fq.delete();
      exp_q.delete();
      remaining   = 0;
      busy_exp    = 1'b0;
      done_exp    = 1'b0;
      outstanding = 0;
      prev_stall  = 1'b0;
      fifo_dout  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      idle      = (remaining == 0) && !done_exp;
      done_next = 1'b0;
      if (m_valid && m_ready) begin
        seen_q.push_back(m_data);
        seen_cyc.push_back(cyc);
        chk("hs_word_owed", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("m_data_order", 32'(m_data), 32'(exp_q.pop_front()));
        chk("hs_in_burst", 32'(remaining != 0), 1);
        if (remaining > 0) begin
          remaining--;
          if (remaining == 0) done_next = 1'b1;
        end
        outstanding--;
      end
      if (idle && cmd_start) begin
        if (cmd_len == '0) done_next = 1'b1;
        else remaining = int'(cmd_len);
      end
      if (fifo_rd_en) begin
        rd_cnt++;
        chk("rd_en_while_empty", 32'(fifo_empty), 0);
        if (fq.size() != 0) begin
          fifo_dout <= fq.pop_front();
          outstanding++;
        end
      end
      fifo_empty <= (fq.size() == 0);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      done_exp   = done_next;
      busy_exp   = (remaining != 0);
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy", 32'(busy), 32'(busy_exp));
      chk("done", 32'(done), 32'(done_exp));
      chk("inflight_bound", 32'(outstanding <= 2), 1);
      if (prev_stall) begin
        chk("stall_valid_held", 32'(m_valid), 1);
        chk("stall_data_held", 32'(m_data), 32'(prev_data));
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic start(input int len);
    cmd_start = 1'b1;
    cmd_len   = LEN_W'(len);
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < budget), 1);
  endtask

  task automatic wait_valid(input string name, input int budget, output int n);
    n = 1;
    while (!m_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < budget), 1);
  endtask

  // Burst with random backpressure and words trickling into the FIFO while it runs.
  task automatic run_burst(input int len, input int prepush, input bit gen_words);
    int pushed;
    int n;
    pushed = 0;
    if (gen_words) begin
      for (int i = 0; i < prepush; i++) push(8'($urandom));
      pushed = prepush;
    end else begin
      pushed = len;
    end
    start(len);
    n = 0;
    while (!done && n < 400) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if (pushed < len && $urandom_range(0, 1) == 1) begin
        push(8'($urandom));
        pushed++;
      end
      @(negedge clk);
      n++;
    end
    chk("rand_burst_done", 32'(n < 400), 1);
    m_ready = 1'b1;
    tick(1);
  endtask

  initial begin
    int v;
    int rd0;
    int dc0;
    int len;

    rst = 1'b1;
    tick(2);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_m_valid", 32'(m_valid), 0);
    chk("reset_m_data", 32'(m_data), 0);
    chk("reset_rd_en", 32'(fifo_rd_en), 0);
    rst = 1'b0;
    tick(1);

    // Basic four-word burst with the consumer always ready.
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    m_ready = 1'b1;
    tick(1);
    seen_q.delete();
    seen_cyc.delete();
    dc0 = done_cnt;
    start(4);
    wait_valid("t1_valid_timeout", 10, v);
    chk("t1_first_valid_latency", 32'(v), 3);
    wait_done("t1_done_timeout", 40);
    tick(2);
    chk("t1_word_count", 32'(seen_q.size()), 4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++) begin
      chk("t1_word_value", 32'(seen_q[i]), 32'h10 + 32'(i));
      chk("t1_back_to_back", 32'(seen_cyc[i] - seen_cyc[0]), 32'(i));
    end
    chk("t1_done_pulses", 32'(done_cnt - dc0), 1);
    chk("t1_fifo_empty", 32'(fifo_empty), 1);
    chk("t1_model_drained", 32'(exp_q.size()), 0);

    // Same burst with the consumer stalled after the first word appears.
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    m_ready = 1'b0;
    tick(1);
    seen_q.delete();
    rd0 = rd_cnt;
    start(4);
    wait_valid("t2_valid_timeout", 10, v);
    tick(5);
    chk("t2_reads_before_release", 32'(rd_cnt - rd0), 2);
    chk("t2_held_word", 32'(m_data), 32'h10);
    m_ready = 1'b1;
    wait_done("t2_done_timeout", 40);
    tick(1);
    chk("t2_word_count", 32'(seen_q.size()), 4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++)
      chk("t2_word_value", 32'(seen_q[i]), 32'h10 + 32'(i));

    // Starvation: one word queued for a three-word burst.
    push(8'hA1);
    tick(1);
    seen_q.delete();
    rd0 = rd_cnt;
    start(3);
    tick(8);
    chk("t3_busy_while_starved", 32'(busy), 1);
    chk("t3_reads_while_starved", 32'(rd_cnt - rd0), 1);
    chk("t3_first_word", 32'(seen_q.size() > 0 ? seen_q[0] : 8'h00), 32'hA1);
    push(8'hA2);
    tick(2);
    push(8'hA3);
    wait_done("t3_done_timeout", 40);
    tick(1);
    chk("t3_word_count", 32'(seen_q.size()), 3);
    if (seen_q.size() == 3) begin
      chk("t3_second_word", 32'(seen_q[1]), 32'hA2);
      chk("t3_third_word", 32'(seen_q[2]), 32'hA3);
    end

    // Zero-length command completes without touching the FIFO.
    rd0 = rd_cnt;
    dc0 = done_cnt;
    start(0);
    chk("t4_done_next_cycle", 32'(done), 1);
    chk("t4_busy_low", 32'(busy), 0);
    tick(3);
    chk("t4_no_reads", 32'(rd_cnt - rd0), 0);
    chk("t4_done_pulses", 32'(done_cnt - dc0 + (done ? 0 : 0)), 1);

    // Two back-to-back 16-word bursts under random backpressure.
    dc0 = done_cnt;
    for (int i = 0; i < 16; i++) push(8'($urandom));
    run_burst(16, 0, 1'b0);
    for (int i = 0; i < 16; i++) push(8'(i));
    run_burst(16, 0, 1'b0);
    chk("t5_done_pulses", 32'(done_cnt - dc0), 2);
    chk("t5_model_drained", 32'(exp_q.size()), 0);

    // Random bursts with words arriving while the burst runs.
    for (int b = 0; b < 12; b++) begin
      len = $urandom_range(1, 31);
      run_burst(len, $urandom_range(0, len), 1'b1);
    end
    chk("rand_model_drained", 32'(exp_q.size()), 0);

    // Reset in the middle of a six-word burst.
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
    tick(1);
    seen_q.delete();
    start(6);
    v = 0;
    while (seen_q.size() < 2 && v < 20) begin
      @(negedge clk);
      v++;
    end
    chk("t6_two_handshakes", 32'(v < 20), 1);
    dc0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_m_valid_cleared", 32'(m_valid), 0);
    chk("t6_busy_cleared", 32'(busy), 0);
    chk("t6_m_data_cleared", 32'(m_data), 0);
    tick(4);
    chk("t6_no_done_pulse", 32'(done_cnt - dc0), 0);
    seen_q.delete();
    push(8'h55);
    push(8'h66);
    start(2);
    wait_done("t6_done_timeout", 40);
    tick(1);
    chk("t6_word_count", 32'(seen_q.size()), 2);
    if (seen_q.size() == 2) begin
      chk("t6_first_word", 32'(seen_q[0]), 32'h55);
      chk("t6_second_word", 32'(seen_q[1]), 32'h66);
    end

    tick(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
